auteur_dotp_ctrl: RTL
=====================

Name: auteur_dotp_ctrl

Overview:
- Issue controller for the pipelined block-scaled dot-product unit.
- Accepts commands of N operand beats and streams the beats into the fixed-latency pipeline, which has no stall.
- Drives the pipeline's first/last (accumulator clear/commit) markers, tracks in-flight beats, and reserves result-buffer credits so a finished result is never dropped.
- Sits between the operand feeder/command queue and the dotp datapath plus its result buffer.

Parameters:
- PipeLatency, 8, total pipeline depth from beat issue to result valid. Equals the sum of all stage delays in the pipe config. Must be ≥1.
- BeatsWidth, 8, width of the command beat count.
- ResultCredits, 2, result-buffer entries downstream. Must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_beats_i  in  BeatsWidth  number of beats; 0 is treated as 1
- beat_valid_i  in  1  operand beat available from feeder
- beat_ready_o  out  1  beat consumed (issued) this cycle
- pipe_valid_o  out  1  beat enters pipeline this cycle
- pipe_first_o  out  1  first beat of command (clear accumulator)
- pipe_last_o  out  1  last beat of command (commit accumulator)
- res_valid_o  out  1  result available at pipeline output/buffer
- res_ready_i  in  1  result consumed
- busy_o  out  1  command active or beats in flight
- credits_o  out  $clog2(ResultCredits+1)  free result credits

Behaviour:
- Reset values: cmd_ready_o=1, all other 1-bit outputs 0, credits_o=ResultCredits, shift register cleared, state IDLE.
- States:
  - IDLE: cmd_ready_o=1. On cmd handshake, latch beats (0→1), set remaining=beats, go to ISSUE.
  - ISSUE: cmd_ready_o=0 except on the cycle the last beat issues.
- Issue condition (ISSUE only): beat_valid_i & (not first beat | credits>0).
  - beat_ready_o = pipe_valid_o = issue condition. This is combinational from beat_valid_i and state.
  - pipe_first_o is asserted on the first issued beat. The credit decrements in that same cycle (reservation).
  - pipe_last_o is asserted when remaining==1. One-beat commands assert first and last together.
  - Each issue decrements remaining.
- Last-beat issue cycle: cmd_ready_o=1.
  - A new command accepted in the same cycle loads directly and stays in ISSUE. Back-to-back first beat follows the next cycle with no bubble.
  - Otherwise go to IDLE.
- No-credit case: the first beat is held (beat_ready_o=0) while credits==0. Later beats of an already-started command never wait on credits.
- In-flight tracking:
  - PipeLatency-entry shift register of {valid,last}, shifted every cycle (the pipeline never stalls).
  - When an entry with last=1 shifts out, pending_results increments.
  - Last beat issued in cycle t → res_valid_o high from cycle t+PipeLatency.
- Result drain:
  - res_valid_o = pending_results≠0.
  - A handshake decrements pending_results and increments credits in the same cycle.
  - A simultaneous pending increment and decrement leaves the count unchanged.
  - Credit reserve and release in the same cycle leave credits unchanged.
- Invariant: pending_results + in-flight commands + credits == ResultCredits. An assertion flags any violation.
- busy_o = state≠IDLE | any shift-register valid | pending_results≠0.
- Asynchronous reset mid-operation drops all in-flight tracking and returns to reset values. The datapath is reset by the same rst_ni.

Optional Feature:
- Macro AUTEUR_DOTP_CTRL_PERF_EN.
- When defined, adds output ports:
  - stall_cnt_o [31:0]: cycles in ISSUE with beat_valid_i=0, or with the first beat blocked by credits==0.
  - issue_cnt_o [31:0]: issued beats.
  - Both counters saturate at all-ones and reset to 0.
- When not defined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Defaults; cmd beats=4, beat_valid_i held 1 → pipe_valid_o high cycles 1–4 after accept, first on cycle 1, last on cycle 4; res_valid_o at cycle 4+8=12; credits 2→1, back to 2 on res handshake.
- cmd beats=0 → single beat with first=last=1; one result after 8 cycles.
- Three 1-beat commands back-to-back, res_ready_i=0 → third first-beat held with credits_o=0; after one res handshake the third beat issues the next cycle.
- Two back-to-back cmds (3 beats then 2) → five consecutive pipe_valid_o cycles with no gap, first at beats 1 and 4, last at beats 3 and 5.
- beat_valid_i toggling 1010 during a 4-beat cmd → beats issue only on valid cycles; markers are still correct; result 8 cycles after last issue.
- Reset asserted with 3 beats in flight and 1 pending result → all outputs at reset values immediately; after release, busy_o=0 and credits_o=2.

Source files
------------

// File: rtl/auteur_dotp_ctrl_if.sv
// rtl/auteur_dotp_ctrl_if.sv - command, beat, pipeline-marker and result signals of the dotp issue controller
interface auteur_dotp_ctrl_if #(
  parameter int BeatsWidth    = 8,
  parameter int ResultCredits = 2
);
  localparam int CredW = $clog2(ResultCredits + 1);

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [BeatsWidth-1:0] cmd_beats_i;
  logic                  beat_valid_i;
  logic                  beat_ready_o;
  logic                  pipe_valid_o;
  logic                  pipe_first_o;
  logic                  pipe_last_o;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic                  busy_o;
  logic [CredW-1:0]      credits_o;

  modport master (
    input  cmd_valid_i, cmd_beats_i, beat_valid_i, res_ready_i,
    output cmd_ready_o, beat_ready_o, pipe_valid_o, pipe_first_o, pipe_last_o,
           res_valid_o, busy_o, credits_o
  );

  modport slave (
    output cmd_valid_i, cmd_beats_i, beat_valid_i, res_ready_i,
    input  cmd_ready_o, beat_ready_o, pipe_valid_o, pipe_first_o, pipe_last_o,
           res_valid_o, busy_o, credits_o
  );
endinterface

// File: rtl/auteur_dotp_ctrl.sv
// rtl/auteur_dotp_ctrl.sv - issue controller for the no-stall dotp pipeline with result-credit reservation
// Optional perf counters (stall_cnt_o, issue_cnt_o) under AUTEUR_DOTP_CTRL_PERF_EN.
module auteur_dotp_ctrl #(
  parameter int PipeLatency   = 8,
  parameter int BeatsWidth    = 8,
  parameter int ResultCredits = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  auteur_dotp_ctrl_if.master bus
`ifdef AUTEUR_DOTP_CTRL_PERF_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        issue_cnt_o
`endif
);
  localparam int CredW = $clog2(ResultCredits + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                state;
  logic [BeatsWidth-1:0] remaining;
  logic                  first_pending;
  logic [CredW-1:0]      credits;
  logic [CredW-1:0]      pending;
  logic [BeatsWidth-1:0] cmd_beats_eff;
  logic                  issue;
  logic                  last_issue;
  logic                  cmd_fire;
  logic                  reserve;
  logic                  res_fire;
  logic                  tap_valid;
  logic                  tap_last;
  logic                  sr_any;
  int unsigned           inflight_lasts;

  // A command's first beat may only enter the pipe once a result slot is reserved for it.
  assign issue      = (state == ISSUE) && bus.beat_valid_i && (!first_pending || credits != '0);
  assign last_issue = issue && (remaining == BeatsWidth'(1));
  assign reserve    = issue && first_pending;

  assign bus.cmd_ready_o  = (state == IDLE) || last_issue;
  assign cmd_fire         = bus.cmd_valid_i && bus.cmd_ready_o;
  assign cmd_beats_eff    = (bus.cmd_beats_i == '0) ? BeatsWidth'(1) : bus.cmd_beats_i;

  assign bus.beat_ready_o = issue;
  assign bus.pipe_valid_o = issue;
  assign bus.pipe_first_o = reserve;
  assign bus.pipe_last_o  = last_issue;

  assign bus.res_valid_o  = (pending != '0);
  assign res_fire         = bus.res_valid_o && bus.res_ready_i;
  assign bus.credits_o    = credits;
  assign bus.busy_o       = (state != IDLE) || sr_any || (pending != '0);

  // The tap sits one stage before the pipe output so the pending count is visible exactly
  // PipeLatency cycles after the last beat issues.
  if (PipeLatency == 1) begin : g_no_sr
    assign tap_valid      = issue;
    assign tap_last       = last_issue;
    assign sr_any         = 1'b0;
    assign inflight_lasts = 0;
  end else begin : g_sr
    logic [PipeLatency-2:0] sr_valid;
    logic [PipeLatency-2:0] sr_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sr_valid <= '0;
        sr_last  <= '0;
      end else begin
        sr_valid[0] <= issue;
        sr_last[0]  <= last_issue;
        for (int i = 1; i < PipeLatency - 1; i++) begin
          sr_valid[i] <= sr_valid[i-1];
          sr_last[i]  <= sr_last[i-1];
        end
      end
    end

    always_comb begin
      inflight_lasts = 0;
      for (int i = 0; i < PipeLatency - 1; i++) begin
        inflight_lasts = inflight_lasts + int'(sr_last[i]);
      end
    end

    assign tap_valid = sr_valid[PipeLatency-2];
    assign tap_last  = sr_last[PipeLatency-2];
    assign sr_any    = |sr_valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      remaining     <= '0;
      first_pending <= 1'b0;
      credits       <= CredW'(ResultCredits);
      pending       <= '0;
    end else begin
      if (cmd_fire) begin
        state         <= ISSUE;
        remaining     <= cmd_beats_eff;
        first_pending <= 1'b1;
      end else if (issue) begin
        remaining     <= remaining - BeatsWidth'(1);
        first_pending <= 1'b0;
        if (last_issue) state <= IDLE;
      end
      credits <= credits + CredW'(res_fire) - CredW'(reserve);
      pending <= pending + CredW'(tap_valid && tap_last) - CredW'(res_fire);
    end
  end

  // Every reserved credit is either mid-command, travelling as a last beat, or a pending result.
  a_credit_conservation : assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(pending) + int'(inflight_lasts) + int'(state == ISSUE && !first_pending) + int'(credits)
      == ResultCredits);

`ifdef AUTEUR_DOTP_CTRL_PERF_EN
  logic stall;
  assign stall = (state == ISSUE) && (!bus.beat_valid_i || (first_pending && credits == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      issue_cnt_o <= '0;
    end else begin
      if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (issue && issue_cnt_o != '1) issue_cnt_o <= issue_cnt_o + 32'd1;
    end
  end
`endif
endmodule
